mem_arbiter: RTL and testbench

- Shares one single-ported, multi-cycle unified memory between the fetch stage (instruction reads) and the memory stage (data reads and writes).
- Sequences each access: grant, issue, wait for completion, respond.
- Returns per-port done/err pulses that the pipeline uses as stall-release.
- Sits between fetch/memory stages and the backing memory model.

---
 rtl/mem_arbiter_pkg.sv | 16 +
 rtl/mem_arb_timer.sv | 27 ++
 rtl/mem_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the unified-memory arbiter: FSM encodings, owner codes
// and default timing limits.
package mem_arbiter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  localparam int TIMEOUT_DEF    = 15;
  localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/mem_arb_timer.sv
// Clearable, enabled counter that saturates at MAX; tc is high while the count
// sits at MAX. Clear wins over enable.
module mem_arb_timer #(
  parameter int MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int W = (MAX < 1) ? 1 : $clog2(MAX + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && (cnt != W'(MAX))) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == W'(MAX));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one multi-cycle memory between fetch reads and data reads/writes:
// grant, issue, wait for mem_done (or time out), then pulse done/err to the owner.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT    = TIMEOUT_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_rdata,
  output logic        if_done,
  output logic        if_err,
  input  logic        dm_rd,
  input  logic        dm_wr,
  input  logic [15:0] dm_addr,
  input  logic [15:0] dm_wdata,
  output logic [15:0] dm_rdata,
  output logic        dm_done,
  output logic        dm_err,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_done,
  output logic        busy
);

  // Requests are levels: a requester holds if_req / dm_rd / dm_wr with stable
  // address and data until its one-cycle done or err pulse, and drops or
  // replaces the request in the following cycle.

  logic [1:0] state;
  logic       owner;
  logic       dm_req, grant_dm, grant_if, req_bad;
  logic       starve_clr, starve_en, starve_tc;
  logic       to_clr, to_en, to_tc;

  always_comb begin
    dm_req   = dm_rd | dm_wr;
    grant_dm = 1'b0;
    grant_if = 1'b0;
    if (state == ST_IDLE) begin
      grant_dm = dm_req && !(if_req && starve_tc);
      grant_if = !grant_dm && if_req;
    end
    req_bad    = grant_dm ? ((dm_rd & dm_wr) | dm_addr[0]) : if_addr[0];
    // Rejected requests never touch the starvation count.
    starve_clr = !req_bad && (grant_if || (grant_dm && !if_req));
    starve_en  = !req_bad && grant_dm && if_req;
    to_clr     = (state == ST_ISSUE);
    to_en      = (state == ST_WAIT) && !mem_done;
  end

  mem_arb_timer #(.MAX(STARVE_MAX)) u_starve (
    .clk (clk),
    .rst (rst),
    .clr (starve_clr),
    .en  (starve_en),
    .tc  (starve_tc)
  );

  // Terminal count lands on the last permitted WAIT cycle.
  mem_arb_timer #(.MAX(TIMEOUT - 1)) u_timeout (
    .clk (clk),
    .rst (rst),
    .clr (to_clr),
    .en  (to_en),
    .tc  (to_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      owner     <= OWN_IF;
      busy      <= 1'b0;
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_done   <= 1'b0;
      if_err    <= 1'b0;
      dm_done   <= 1'b0;
      dm_err    <= 1'b0;
    end else begin
      mem_en  <= 1'b0;
      if_done <= 1'b0;
      if_err  <= 1'b0;
      dm_done <= 1'b0;
      dm_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_dm || grant_if) begin
            owner <= grant_dm ? OWN_DM : OWN_IF;
            busy  <= 1'b1;
            if (req_bad) begin
              state <= ST_RESP;
              if (grant_dm) dm_err <= 1'b1;
              else          if_err <= 1'b1;
            end else begin
              state     <= ST_ISSUE;
              mem_en    <= 1'b1;
              mem_wr    <= grant_dm & dm_wr;
              mem_addr  <= grant_dm ? dm_addr : if_addr;
              mem_wdata <= grant_dm ? dm_wdata : '0;
            end
          end
        end
        ST_ISSUE: state <= ST_WAIT;
        ST_WAIT: begin
          if (mem_done) begin
            state <= ST_RESP;
            if (owner == OWN_DM) begin
              dm_done <= 1'b1;
              if (!mem_wr) dm_rdata <= mem_rdata;
            end else begin
              if_done  <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end else if (to_tc) begin
            state <= ST_RESP;
            if (owner == OWN_DM) dm_err <= 1'b1;
            else                 if_err <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: each task drives one scenario cycle by cycle
// and compares outputs against hand-computed values.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [15:0] if_addr;
  logic [15:0] if_rdata;
  logic        if_done;
  logic        if_err;
  logic        dm_rd;
  logic        dm_wr;
  logic [15:0] dm_addr;
  logic [15:0] dm_wdata;
  logic [15:0] dm_rdata;
  logic        dm_done;
  logic        dm_err;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_done;
  logic        busy;

  int checks = 0;
  int errors = 0;

  mem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_done   (if_done),
    .if_err    (if_err),
    .dm_rd     (dm_rd),
    .dm_wr     (dm_wr),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .dm_done   (dm_done),
    .dm_err    (dm_err),
    .mem_en    (mem_en),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_done  (mem_done),
    .busy      (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; if_req = 1'b0; if_addr = '0; dm_rd = 1'b0; dm_wr = 1'b0;
    dm_addr = '0; dm_wdata = '0; mem_rdata = '0; mem_done = 1'b0;
    step(); step();
    rst = 1'b0;
    checks++; if ({mem_en, mem_wr, busy, if_done, if_err, dm_done, dm_err} !== 7'b0) begin errors++; $display("FAIL reset_flags got %b exp 0000000", {mem_en, mem_wr, busy, if_done, if_err, dm_done, dm_err}); end
    checks++; if ({if_rdata, dm_rdata, mem_addr, mem_wdata} !== 64'h0) begin errors++; $display("FAIL reset_data got %h exp 0", {if_rdata, dm_rdata, mem_addr, mem_wdata}); end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got %b exp 0", busy); end
  endtask

  task automatic test_fetch_read();
    if_req = 1'b1; if_addr = 16'h0010;
    step(); // cycle 1
    checks++; if (mem_en !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 16'h0010) begin errors++; $display("FAIL fetch_issue got en=%b wr=%b addr=%h exp en=1 wr=0 addr=0010", mem_en, mem_wr, mem_addr); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fetch_busy_c1 got %b exp 1", busy); end
    step(); // cycle 2
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL fetch_en_single got %b exp 0", mem_en); end
    step(); step(); // cycle 4
    mem_done = 1'b1; mem_rdata = 16'hA5A5;
    checks++; if (if_done !== 1'b0 || mem_addr !== 16'h0010 || busy !== 1'b1) begin errors++; $display("FAIL fetch_wait_c4 got done=%b addr=%h busy=%b exp done=0 addr=0010 busy=1", if_done, mem_addr, busy); end
    step(); // cycle 5
    mem_done = 1'b0; if_req = 1'b0;
    checks++; if (if_done !== 1'b1 || if_err !== 1'b0 || dm_done !== 1'b0) begin errors++; $display("FAIL fetch_done_c5 got if_done=%b if_err=%b dm_done=%b exp 1 0 0", if_done, if_err, dm_done); end
    checks++; if (if_rdata !== 16'hA5A5) begin errors++; $display("FAIL fetch_rdata got %h exp a5a5", if_rdata); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fetch_busy_c5 got %b exp 1", busy); end
    step(); // cycle 6
    checks++; if (if_done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL fetch_after got done=%b busy=%b exp 0 0", if_done, busy); end
  endtask

  task automatic test_data_read();
    dm_rd = 1'b1; dm_addr = 16'h0030;
    step();
    checks++; if (mem_en !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 16'h0030) begin errors++; $display("FAIL dread_issue got en=%b wr=%b addr=%h exp 1 0 0030", mem_en, mem_wr, mem_addr); end
    step();
    mem_done = 1'b1; mem_rdata = 16'hBEEF;
    step();
    mem_done = 1'b0; dm_rd = 1'b0;
    checks++; if (dm_done !== 1'b1 || if_done !== 1'b0 || dm_rdata !== 16'hBEEF) begin errors++; $display("FAIL dread_done got dm_done=%b if_done=%b rdata=%h exp 1 0 beef", dm_done, if_done, dm_rdata); end
    checks++; if (if_rdata !== 16'hA5A5) begin errors++; $display("FAIL dread_if_rdata_hold got %h exp a5a5", if_rdata); end
    step();
  endtask

  task automatic test_data_write();
    dm_wr = 1'b1; dm_addr = 16'h0020; dm_wdata = 16'h1234;
    step();
    checks++; if (mem_en !== 1'b1 || mem_wr !== 1'b1 || mem_addr !== 16'h0020 || mem_wdata !== 16'h1234) begin errors++; $display("FAIL dwrite_issue got en=%b wr=%b addr=%h wdata=%h exp 1 1 0020 1234", mem_en, mem_wr, mem_addr, mem_wdata); end
    step();
    checks++; if (mem_wdata !== 16'h1234 || mem_en !== 1'b0) begin errors++; $display("FAIL dwrite_hold got wdata=%h en=%b exp 1234 0", mem_wdata, mem_en); end
    mem_done = 1'b1; mem_rdata = 16'h5555;
    step();
    mem_done = 1'b0; dm_wr = 1'b0;
    checks++; if (dm_done !== 1'b1 || dm_err !== 1'b0) begin errors++; $display("FAIL dwrite_done got done=%b err=%b exp 1 0", dm_done, dm_err); end
    checks++; if (dm_rdata !== 16'hBEEF) begin errors++; $display("FAIL dwrite_rdata_unchanged got %h exp beef", dm_rdata); end
    step();
    checks++; if (dm_done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL dwrite_single_pulse got done=%b busy=%b exp 0 0", dm_done, busy); end
  endtask

  task automatic test_starvation();
    logic [15:0] exp_q[$];
    logic [9:0]  fetch_slot;
    logic [15:0] exp_addr;
    logic [15:0] exp_rd;
    int          n;
    fetch_slot = 10'b10_0001_0000; // grant order D D D D I D D D D I
    for (int g = 0; g < 10; g++) exp_q.push_back(fetch_slot[g] ? 16'h0100 : 16'h0200);
    if_req = 1'b1; if_addr = 16'h0100; dm_rd = 1'b1; dm_addr = 16'h0200;
    for (int g = 0; g < 10; g++) begin
      n = 0;
      while (mem_en !== 1'b1 && n < 8) begin step(); n++; end
      checks++;
      if (n == 8) begin errors++; $display("FAIL starve_grant_wait grant %0d got no mem_en exp mem_en within 8 cycles", g); break; end
      exp_addr = exp_q.pop_front();
      checks++; if (mem_addr !== exp_addr) begin errors++; $display("FAIL starve_order grant %0d got addr %h exp %h", g, mem_addr, exp_addr); end
      step();
      exp_rd = 16'(16'h1000 + g);
      mem_done = 1'b1; mem_rdata = exp_rd;
      step();
      mem_done = 1'b0;
      if (g == 9) begin if_req = 1'b0; dm_rd = 1'b0; end
      checks++;
      if (exp_addr == 16'h0100) begin
        if (if_done !== 1'b1 || dm_done !== 1'b0 || if_rdata !== exp_rd) begin errors++; $display("FAIL starve_resp grant %0d got if_done=%b dm_done=%b if_rdata=%h exp 1 0 %h", g, if_done, dm_done, if_rdata, exp_rd); end
      end else begin
        if (dm_done !== 1'b1 || if_done !== 1'b0 || dm_rdata !== exp_rd) begin errors++; $display("FAIL starve_resp grant %0d got dm_done=%b if_done=%b dm_rdata=%h exp 1 0 %h", g, dm_done, if_done, dm_rdata, exp_rd); end
      end
    end
    step(); step();
    checks++; if (busy !== 1'b0 || mem_en !== 1'b0) begin errors++; $display("FAIL starve_idle got busy=%b en=%b exp 0 0", busy, mem_en); end
  endtask

  task automatic test_errors();
    dm_rd = 1'b1; dm_wr = 1'b1; dm_addr = 16'h0040;
    step();
    dm_rd = 1'b0; dm_wr = 1'b0;
    checks++; if (dm_err !== 1'b1 || dm_done !== 1'b0 || mem_en !== 1'b0) begin errors++; $display("FAIL err_rdwr got err=%b done=%b en=%b exp 1 0 0", dm_err, dm_done, mem_en); end
    step();
    checks++; if (dm_err !== 1'b0 || busy !== 1'b0 || mem_en !== 1'b0) begin errors++; $display("FAIL err_rdwr_after got err=%b busy=%b en=%b exp 0 0 0", dm_err, busy, mem_en); end
    if_req = 1'b1; if_addr = 16'h0011;
    step();
    if_req = 1'b0;
    checks++; if (if_err !== 1'b1 || if_done !== 1'b0 || mem_en !== 1'b0) begin errors++; $display("FAIL err_if_unaligned got err=%b done=%b en=%b exp 1 0 0", if_err, if_done, mem_en); end
    step();
    dm_rd = 1'b1; dm_addr = 16'h0021;
    step();
    dm_rd = 1'b0;
    checks++; if (dm_err !== 1'b1 || if_err !== 1'b0 || mem_en !== 1'b0) begin errors++; $display("FAIL err_dm_unaligned got dm_err=%b if_err=%b en=%b exp 1 0 0", dm_err, if_err, mem_en); end
    step();
  endtask

  task automatic test_timeout();
    logic early_pulse;
    early_pulse = 1'b0;
    if_req = 1'b1; if_addr = 16'h0050;
    step(); // cycle 1: ISSUE
    checks++; if (mem_en !== 1'b1 || mem_addr !== 16'h0050) begin errors++; $display("FAIL tmo_issue got en=%b addr=%h exp 1 0050", mem_en, mem_addr); end
    for (int c = 2; c <= 16; c++) begin
      step();
      if (if_err !== 1'b0 || if_done !== 1'b0 || busy !== 1'b1) early_pulse = 1'b1;
    end
    checks++; if (early_pulse !== 1'b0) begin errors++; $display("FAIL tmo_early got early pulse/idle=%b exp 0", early_pulse); end
    step(); // cycle 17
    if_req = 1'b0;
    checks++; if (if_err !== 1'b1 || if_done !== 1'b0) begin errors++; $display("FAIL tmo_err got err=%b done=%b exp 1 0", if_err, if_done); end
    step();
    checks++; if (if_err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL tmo_idle got err=%b busy=%b exp 0 0", if_err, busy); end
    mem_done = 1'b1; mem_rdata = 16'hDEAD;
    step();
    mem_done = 1'b0;
    checks++; if (if_done !== 1'b0 || if_err !== 1'b0 || busy !== 1'b0 || if_rdata !== 16'h1009) begin errors++; $display("FAIL tmo_late_done got done=%b err=%b busy=%b rdata=%h exp 0 0 0 1009", if_done, if_err, busy, if_rdata); end
  endtask

  task automatic test_reset_mid_wait();
    if_req = 1'b1; if_addr = 16'h0060;
    step(); step(); step(); // cycle 3: WAIT
    rst = 1'b1;
    step();
    rst = 1'b0; if_req = 1'b0;
    checks++; if ({mem_en, busy, if_done, if_err, dm_done, dm_err} !== 6'b0) begin errors++; $display("FAIL rstmid_flags got %b exp 000000", {mem_en, busy, if_done, if_err, dm_done, dm_err}); end
    checks++; if (mem_addr !== 16'h0 || if_rdata !== 16'h0) begin errors++; $display("FAIL rstmid_data got addr=%h rdata=%h exp 0 0", mem_addr, if_rdata); end
    mem_done = 1'b1; mem_rdata = 16'hBAD0;
    step();
    mem_done = 1'b0;
    checks++; if (if_done !== 1'b0 || if_err !== 1'b0 || busy !== 1'b0 || if_rdata !== 16'h0) begin errors++; $display("FAIL rstmid_stray got done=%b err=%b busy=%b rdata=%h exp 0 0 0 0", if_done, if_err, busy, if_rdata); end
    if_req = 1'b1; if_addr = 16'h0070;
    step();
    checks++; if (mem_en !== 1'b1 || mem_addr !== 16'h0070) begin errors++; $display("FAIL rstmid_new_issue got en=%b addr=%h exp 1 0070", mem_en, mem_addr); end
    step();
    mem_done = 1'b1; mem_rdata = 16'h7777;
    step();
    mem_done = 1'b0; if_req = 1'b0;
    checks++; if (if_done !== 1'b1 || if_rdata !== 16'h7777) begin errors++; $display("FAIL rstmid_new_done got done=%b rdata=%h exp 1 7777", if_done, if_rdata); end
    step();
  endtask

  initial begin
    test_reset();
    test_fetch_read();
    test_data_read();
    test_data_write();
    test_starvation();
    test_errors();
    test_timeout();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
